// File: rtl/request_unit_if.sv
// Handshake bundle between the control unit, memory and request_unit.
// The master modport is the environment side, the slave modport is request_unit.
interface request_unit_if;
  logic        cu_iREN;
  logic        cu_dREN;
  logic        cu_dWEN;
  logic        cu_datomic;
  logic        cu_halt;
  logic [31:0] daddr;
  logic        ihit;
  logic        dhit;
  logic        iREN;
  logic        dREN;
  logic        dWEN;
  logic        pc_en;
  logic        sc_ok;
  logic        halted;

  modport master (
    output cu_iREN, cu_dREN, cu_dWEN, cu_datomic, cu_halt, daddr, ihit, dhit,
    input  iREN, dREN, dWEN, pc_en, sc_ok, halted
  );

  modport slave (
    input  cu_iREN, cu_dREN, cu_dWEN, cu_datomic, cu_halt, daddr, ihit, dhit,
    output iREN, dREN, dWEN, pc_en, sc_ok, halted
  );
endinterface

// File: rtl/request_unit.sv
// Sequences instruction fetches and data accesses to memory and pulses pc_en on retirement.
// Define ATOMIC_EN to compile in the LL/SC link register and sc_ok reporting.
module request_unit (
  input  logic          CLK,
  input  logic          nRST,
  request_unit_if.slave ru
);
  typedef enum logic [1:0] { FETCH, DACCESS, HALT } state_t;

  state_t state_q;
  logic   dren_q;
  logic   dwen_q;
  logic   halted_q;
  logic   pc_en_q;
  logic   fetch_done;
  logic   mem_op;
  logic   sc_fail;
  logic   pc_en_d;

`ifdef ATOMIC_EN
  logic        atomic_q;
  logic        sc_ok_q;
  logic        link_valid_q;
  logic [31:0] link_addr_q;
`else
  logic unused_atomic;
  assign unused_atomic = ^{ru.cu_datomic, ru.daddr};
`endif

  always_comb begin
    // NOTE: every signal written here is given a value first, so no latch can be inferred.
    sc_fail = 1'b0;
`ifdef ATOMIC_EN
    if (ru.cu_dWEN && ru.cu_datomic)
      sc_fail = !(link_valid_q && (link_addr_q == ru.daddr));
`endif
    // An ihit right after a retirement is dropped so pc_en never pulses twice in a row.
    fetch_done = (state_q == FETCH) && ru.ihit && !pc_en_q;
    mem_op     = ru.cu_dREN || ru.cu_dWEN;
    pc_en_d    = nRST && ((fetch_done && !ru.cu_halt && (!mem_op || sc_fail)) ||
                          ((state_q == DACCESS) && ru.dhit));
  end

  assign ru.iREN   = (state_q == FETCH) && ru.cu_iREN;
  assign ru.dREN   = dren_q;
  assign ru.dWEN   = dwen_q;
  assign ru.pc_en  = pc_en_d;
  assign ru.halted = halted_q;
`ifdef ATOMIC_EN
  assign ru.sc_ok  = sc_ok_q;
`else
  assign ru.sc_ok  = 1'b0;
`endif

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH;
      dren_q       <= 1'b0;
      dwen_q       <= 1'b0;
      halted_q     <= 1'b0;
      pc_en_q      <= 1'b0;
`ifdef ATOMIC_EN
      // NOTE: the link address is ordinary flop storage, so it is cleared with everything else.
      atomic_q     <= 1'b0;
      sc_ok_q      <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
`endif
    end else begin
      pc_en_q <= pc_en_d;
      case (state_q)
        FETCH: begin
          if (fetch_done) begin
            if (ru.cu_halt) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else if (mem_op && !sc_fail) begin
              state_q  <= DACCESS;
              dren_q   <= ru.cu_dREN && !ru.cu_dWEN;
              dwen_q   <= ru.cu_dWEN;
`ifdef ATOMIC_EN
              atomic_q <= ru.cu_datomic;
            end else if (sc_fail) begin
              sc_ok_q  <= 1'b0;
`endif
            end
          end
        end
        DACCESS: begin
          if (ru.dhit) begin
            state_q <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
`ifdef ATOMIC_EN
            if (atomic_q && dwen_q) begin
              sc_ok_q      <= 1'b1;
              link_valid_q <= 1'b0;
            end else if (atomic_q) begin
              link_valid_q <= 1'b1;
              link_addr_q  <= ru.daddr;
            end else if (dwen_q && (ru.daddr == link_addr_q)) begin
              link_valid_q <= 1'b0;
            end
`endif
          end
        end
        HALT:    state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
  end
endmodule

// File: doc/request_unit.md
REQUEST_UNIT -- requirements
Module: request_unit

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 nRST  input  1  asynchronous active-low reset.
REQ-003 cu_iREN  input  1  instruction read request from control unit.
REQ-004 cu_dREN  input  1  data read request (LW/LL) from control unit.
REQ-005 cu_dWEN  input  1  data write request (SW/SC) from control unit.
REQ-006 cu_datomic  input  1  current data access is LL (with dREN) or SC (with dWEN).
REQ-007 cu_halt  input  1  decoded HALT instruction.
REQ-008 daddr  input  32  word-aligned data address of current access.
REQ-009 ihit  input  1  instruction memory completed the fetch this cycle.
REQ-010 dhit  input  1  data memory completed the access this cycle.
REQ-011 iREN  output  1  instruction read enable to memory.
REQ-012 dREN  output  1  data read enable to memory.
REQ-013 dWEN  output  1  data write enable to memory.
REQ-014 pc_en  output  1  one-cycle pulse: instruction retired, PC and register file may update.
REQ-015 sc_ok  output  1  SC outcome to write back into rt (1 success, 0 fail).
REQ-016 halted  output  1  sticky halt indication.

Function
REQ-017 States SHALL be FETCH, DACCESS, HALT; reset state FETCH.
REQ-018 FETCH: iREN=cu_iREN, dREN=dWEN=0.
REQ-019 FETCH, ihit=1, cu_halt=1: next HALT, pc_en=0.
REQ-020 FETCH, ihit=1, cu_dREN=cu_dWEN=0, cu_halt=0: pc_en=1 same cycle, stay FETCH.
REQ-021 FETCH, ihit=1, cu_dREN or cu_dWEN: next DACCESS, pc_en=0; dREN/dWEN registered from cu_dREN/cu_dWEN, asserted from the next cycle.
REQ-022 DACCESS: iREN=0; dREN/dWEN held constant until dhit.
REQ-023 DACCESS, dhit=1: pc_en=1 same cycle, dREN=dWEN=0 next cycle, next FETCH.
REQ-024 ihit ignored outside FETCH; dhit ignored outside DACCESS.
REQ-025 cu_dREN and cu_dWEN both high SHALL be treated as a write (dWEN wins).
REQ-026 HALT: iREN=dREN=dWEN=pc_en=0, halted=1, remains until reset.
REQ-027 pc_en SHALL never be high for two consecutive cycles.

Reset
REQ-028 nRST low asynchronously SHALL force state FETCH, iREN=dREN=dWEN=pc_en=sc_ok=halted=0 (iREN follows cu_iREN combinationally once in FETCH), clear link register (valid=0, addr=0).
REQ-029 Reset asserted mid-DACCESS SHALL abandon the access; no pc_en pulse issued.

Configuration
REQ-030 Macro ATOMIC_EN compiles in LL/SC support.
REQ-031 With ATOMIC_EN: 32-bit link address plus valid bit. LL (dREN & datomic) sets link_addr=daddr, valid=1 on its dhit.
REQ-032 With ATOMIC_EN: SC whose daddr equals valid link address issues dWEN normally; on dhit sc_ok=1 and link cleared.
REQ-033 With ATOMIC_EN: SC with no matching valid link SHALL NOT assert dWEN, stays in FETCH, retires with pc_en=1 in the ihit cycle, sc_ok=0.
REQ-034 With ATOMIC_EN: non-atomic store completing (dhit) to the linked address clears valid.
REQ-035 sc_ok updates only when an SC retires; holds otherwise.
REQ-036 Without ATOMIC_EN: cu_datomic ignored, LL/SC behave as LW/SW, sc_ok tied 0, no link storage.

Verification
REQ-037 ALU instr: ihit=1, no mem op -> pc_en=1 same cycle, dREN=dWEN=0.
REQ-038 LW at 0x100, dhit 3 cycles after entering DACCESS -> dREN high exactly 3 cycles, iREN=0 throughout, single pc_en on dhit.
REQ-039 HALT with ihit, then ihit toggling 10 cycles -> halted=1, all enables 0, no pc_en.
REQ-040 ATOMIC_EN: LL 0x200, SC 0x200 -> dWEN asserted, sc_ok=1; second SC 0x200 -> no dWEN, sc_ok=0.
REQ-041 ATOMIC_EN: LL 0x200, SW 0x200, SC 0x200 -> SC fails, sc_ok=0, dWEN never asserted for SC.
REQ-042 nRST pulsed low during DACCESS with dWEN=1 -> dWEN=0 immediately, FETCH after release, no pc_en, link invalid.
